// File: rtl/fifo_uart_tx_drain.sv
// fifo_uart_tx_drain: pops FIFO words and sends each as a start/LSB-first data/stop serial frame
module fifo_uart_tx_drain #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty_n,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy,
    output logic [15:0]      frame_cnt
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("CLKS_PER_BIT must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             baud_end, data_end, stop_end;

    assign baud_end  = baud_q == BW'(CLKS_PER_BIT - 1);
    assign data_end  = bit_q == CW'(WIDTH - 1);
    assign stop_end  = bit_q == CW'(STOP_BITS - 1);
    assign tx        = tx_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != IDLE) || fifo_rd;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_cnt_d = frame_cnt_q;
        fifo_rd     = 1'b0;
        case (state_q)
            IDLE: begin
                fifo_rd = enable && fifo_empty_n && !rst;
                state_d = (enable && fifo_empty_n) ? FETCH : IDLE;
            end
            FETCH: begin
                shift_d = fifo_data;
                baud_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                baud_d  = baud_end ? '0 : baud_q + 1'b1;
                state_d = baud_end ? DATA : START;
            end
            DATA: begin
                baud_d  = baud_end ? '0 : baud_q + 1'b1;
                bit_d   = !baud_end ? bit_q : data_end ? '0 : bit_q + 1'b1;
                shift_d = baud_end ? shift_q >> 1 : shift_q;
                state_d = (baud_end && data_end) ? STOP : DATA;
            end
            STOP: begin
                baud_d      = baud_end ? '0 : baud_q + 1'b1;
                bit_d       = !baud_end ? bit_q : stop_end ? '0 : bit_q + 1'b1;
                state_d     = (baud_end && stop_end) ? IDLE : STOP;
                frame_cnt_d = (baud_end && stop_end) ? frame_cnt_q + 16'd1 : frame_cnt_q;
            end
            default: state_d = IDLE;
        endcase
        // tx follows the next state so the line changes exactly with the state register
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
endmodule
